// File: rtl/trans_pkg.sv
// trans_pkg: lane, row and FIFO-entry types shared by the t8x8 array and its output drain.
package trans_pkg;
    localparam int DEF_N = 8;
    localparam int DEF_W = 32;
    typedef logic [DEF_W-1:0] lane_t;
    typedef lane_t [DEF_N-1:0] row_t;
    typedef struct packed {
        row_t data;
        logic last;
    } row_entry_t;
endpackage

// File: rtl/trans_row_fifo.sv
// trans_row_fifo: synchronous row FIFO with occupancy count.
// The head is read straight from storage and forced to zero while empty.
module trans_row_fifo
    import trans_pkg::*;
#(
    parameter type T = row_entry_t,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  T              wdata_i,
    input  logic          pop_i,
    output T              rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o
);
    T mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [LW-1:0] level_q;
    logic do_push, do_pop;
    assign empty_o = level_q == '0;
    assign full_o = level_q == LW'(DEPTH);
    assign do_pop = pop_i & ~empty_o;
    // a pop frees the slot in the same edge, so a full FIFO can still push
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = empty_o ? '0 : mem_q[rd_q];
    assign level_o = level_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            level_q <= level_q + LW'(do_push) - LW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end
endmodule

// File: rtl/trans_drain.sv
// trans_drain: deskews the t8x8 lane streams into aligned rows, queues them for a valid/ready consumer
// and drives the array's shift credit. TRANS_DRAIN_SKEWCHK_EN adds a sticky cross-lane v/clear check.
module trans_drain
    import trans_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W,
    parameter int DEPTH = 16,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [N-1:0][W-1:0] y_in,
    input  logic [N-1:0]        v_in,
    input  logic [N-1:0]        clear_in,
    output logic                accept,
    output logic [N-1:0][W-1:0] row_data,
    output logic                row_valid,
    input  logic                row_ready,
    output logic                row_last,
    output logic                err_skew,
    output logic [LW-1:0]       level
);
    localparam int CW = $clog2(N);
    typedef struct packed {
        logic [N-1:0][W-1:0] data;
        logic last;
    } entry_t;
    logic [N-1:0][W-1:0] ay;
    logic [N-1:0] av, ac;
    for (genvar i = 0; i < N; i++) begin : g_lane
        if (i == N - 1) begin : g_pass
            assign {ac[i], av[i], ay[i]} = {clear_in[i], v_in[i], y_in[i]};
        end else begin : g_dly
            logic [N-2-i:0][W+1:0] sr_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) sr_q <= '0;
                else if (enable) begin
                    sr_q[0] <= {clear_in[i], v_in[i], y_in[i]};
                    for (int k = 1; k < N - 1 - i; k++) sr_q[k] <= sr_q[k-1];
                end
            end
            assign {ac[i], av[i], ay[i]} = sr_q[N-2-i];
        end
    end
    logic [CW-1:0] cnt_q, cnt_d;
    logic err_q, err_d;
    logic wr, pushed, full, empty, mism;
    entry_t wentry, head;
    // lane 0 governs the row; a clear-carrying row only rewinds the tile counter
    assign wr = enable & av[0] & ~ac[0];
    assign pushed = wr & (~full | (row_valid & row_ready));
    assign wentry = {ay, cnt_q == CW'(N - 1)};
`ifdef TRANS_DRAIN_SKEWCHK_EN
    assign mism = enable & ((av != {N{av[0]}}) | (ac != {N{ac[0]}}));
`else
    assign mism = 1'b0;
`endif
    assign cnt_d = !enable ? cnt_q : ac[0] ? '0 : !pushed ? cnt_q : cnt_q == CW'(N - 1) ? '0 : cnt_q + 1'b1;
    assign err_d = err_q | mism | (wr & ~pushed);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    trans_row_fifo #(.T(entry_t), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (wr),
        .wdata_i (wentry),
        .pop_i   (row_valid & row_ready),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );
    // at most N-1 rows sit in the deskew pipe, plus the one entering now
    assign accept = level <= LW'(DEPTH - N);
    assign row_valid = ~empty;
    assign row_data = head.data;
    assign row_last = head.last;
    assign err_skew = err_q;
endmodule

// File: tb/tb_trans_drain.sv
// tb_trans_drain: table-driven, directed and randomized checks of trans_drain against a row-stream model.
module tb_trans_drain;
    localparam int N = 8, W = 32, DEPTH = 16, LW = $clog2(DEPTH) + 1;
`ifdef TRANS_DRAIN_SKEWCHK_EN
    localparam bit SKEW_ERR = 1'b1;
`else
    localparam bit SKEW_ERR = 1'b0;
`endif
    typedef logic [N-1:0][W-1:0] rowv_t;
    typedef struct packed { rowv_t d; logic v; logic c; } ev_t;
    typedef struct packed { rowv_t d; logic last; } exp_t;
    typedef struct { int n; int lvl; bit acc; bit err; bit vld; } tv_t;

    logic clk = 1'b0;
    logic reset = 1'b1, enable = 1'b0, row_ready = 1'b0;
    rowv_t y_in = '0, row_data;
    logic [N-1:0] v_in = '0, clear_in = '0;
    logic accept, row_valid, row_last, err_skew;
    logic [LW-1:0] level;

    int checks = 0, errors = 0;
    ev_t hist [0:8191];
    exp_t q[$];
    int last_at[$];
    int k = 0, tcnt = 0, skew_lane = -1, serial = 0, pops = 0;

    trans_drain #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .enable(enable), .y_in(y_in), .v_in(v_in), .clear_in(clear_in),
        .accept(accept), .row_data(row_data), .row_valid(row_valid), .row_ready(row_ready),
        .row_last(row_last), .err_skew(err_skew), .level(level)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [N*W:0] act, input logic [N*W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic ev_t row_ev(input int r);
        ev_t e;
        e.v = 1'b1;
        e.c = 1'b0;
        for (int i = 0; i < N; i++) e.d[i] = W'((r << 4) | i);
        return e;
    endfunction

    // one clock: skew the logical event onto the lanes, score any pop, update the model
    task automatic tick(input ev_t e, input logic en);
        if (en) begin
            hist[k] = e;
            for (int i = 0; i < N; i++) begin
                int j = k - i;
                int jv = (i == skew_lane) ? j + 1 : j;
                y_in[i] = j >= 0 ? hist[j].d[i] : '0;
                clear_in[i] = j >= 0 ? hist[j].c : 1'b0;
                v_in[i] = jv >= 0 ? hist[jv].v : 1'b0;
            end
        end
        enable = en;
        chk("accept", accept, (DEPTH - int'(level)) >= N);
        if (row_valid && row_ready) begin
            if (q.size() == 0) chk("spurious_row", row_valid, 1'b0);
            else begin
                exp_t x = q.pop_front();
                chk("row", {row_data, row_last}, x);
            end
            if (row_last) last_at.push_back(pops);
            pops++;
        end
        if (en) begin
            if (e.c) tcnt = 0;
            else if (e.v) begin
                q.push_back({e.d, tcnt == N - 1});
                tcnt = (tcnt + 1) % N;
            end
            k++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0;
        y_in = '0;
        v_in = '0;
        clear_in = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        last_at.delete();
        tcnt = 0; k = 0; skew_lane = -1; serial = 0; pops = 0;
    endtask

    task automatic send(input int n, input bit respect, input int maxc, output int sent);
        sent = 0;
        for (int c = 0; c < maxc && sent < n; c++) begin
            if (!respect || accept) begin
                tick(row_ev(serial), 1'b1);
                serial++;
                sent++;
            end else tick('0, 1'b1);
        end
    endtask

    task automatic flush(input int maxc);
        int c = 0;
        row_ready = 1'b1;
        while ((q.size() != 0 || row_valid) && c < maxc) begin
            tick('0, 1'b1);
            c++;
        end
        chk("drain_pending", q.size(), 0);
        chk("drain_valid", row_valid, 1'b0);
    endtask

    initial begin
        tv_t tv [6];
        int s, s2;
        ev_t e;
        tv[0] = '{0, 0, 1'b1, 1'b0, 1'b0};
        tv[1] = '{1, 1, 1'b1, 1'b0, 1'b1};
        tv[2] = '{8, 8, 1'b1, 1'b0, 1'b1};
        tv[3] = '{9, 9, 1'b0, 1'b0, 1'b1};
        tv[4] = '{16, 16, 1'b0, 1'b0, 1'b1};
        tv[5] = '{17, 16, 1'b0, 1'b1, 1'b1};

        do_reset();
        chk("rst_accept", accept, 1'b1);
        chk("rst_valid", row_valid, 1'b0);
        chk("rst_last", row_last, 1'b0);
        chk("rst_data", row_data, '0);
        chk("rst_err", err_skew, 1'b0);
        chk("rst_level", level, 0);

        // fill level / accept / overflow table, no consumer
        for (int t = 0; t < 6; t++) begin
            do_reset();
            row_ready = 1'b0;
            send(tv[t].n, 1'b0, 40, s);
            for (int c = 0; c < N - 1; c++) tick('0, 1'b1);
            chk($sformatf("tbl%0d_level", t), level, tv[t].lvl);
            chk($sformatf("tbl%0d_accept", t), accept, tv[t].acc);
            chk($sformatf("tbl%0d_err", t), err_skew, tv[t].err);
            chk($sformatf("tbl%0d_valid", t), row_valid, tv[t].vld);
        end

        // single tile with first-valid latency
        do_reset();
        row_ready = 1'b1;
        for (int t = 1; t <= N; t++) begin
            tick(row_ev(serial), 1'b1);
            serial++;
            if (t == N - 1) chk("lat_before", row_valid, 1'b0);
            if (t == N) chk("lat_first", row_valid, 1'b1);
        end
        flush(60);
        chk("tile_lasts", last_at.size(), 1);
        if (last_at.size() == 1) chk("tile_last_pos", last_at[0], 7);
        chk("tile_err", err_skew, 1'b0);

        // backpressure: three tiles against a stalled consumer
        do_reset();
        row_ready = 1'b0;
        send(24, 1'b1, 60, s);
        chk("bp_level", level, 16);
        chk("bp_accept", accept, 1'b0);
        chk("bp_err", err_skew, 1'b0);
        row_ready = 1'b1;
        send(24 - s, 1'b1, 200, s2);
        chk("bp_sent", s + s2, 24);
        flush(200);
        chk("bp_pops", pops, 24);
        chk("bp_lasts", last_at.size(), 3);
        if (last_at.size() == 3) begin
            chk("bp_last0", last_at[0], 7);
            chk("bp_last1", last_at[1], 15);
            chk("bp_last2", last_at[2], 23);
        end
        chk("bp_err_end", err_skew, 1'b0);

        // clear marker mid-tile
        do_reset();
        row_ready = 1'b1;
        send(3, 1'b1, 20, s);
        e = '0;
        e.c = 1'b1;
        tick(e, 1'b1);
        send(8, 1'b1, 40, s);
        flush(60);
        chk("clr_pops", pops, 11);
        chk("clr_lasts", last_at.size(), 1);
        if (last_at.size() == 1) chk("clr_last_pos", last_at[0], 10);

        // lane 5 valid one cycle early
        do_reset();
        row_ready = 1'b1;
        skew_lane = 5;
        send(8, 1'b1, 40, s);
        skew_lane = -1;
        flush(60);
        chk("skew_err", err_skew, SKEW_ERR);
        send(8, 1'b1, 40, s);
        flush(60);
        chk("skew_sticky", err_skew, SKEW_ERR);
        chk("skew_pops", pops, 16);

        // enable freeze for 5 cycles
        do_reset();
        row_ready = 1'b1;
        for (int t = 1; t <= N + 5; t++) begin
            if (t >= 4 && t <= 8) tick('0, 1'b0);
            else begin
                tick(row_ev(serial), 1'b1);
                serial++;
            end
            if (t == N + 4) chk("frz_before", row_valid, 1'b0);
            if (t == N + 5) chk("frz_first", row_valid, 1'b1);
        end
        flush(60);
        chk("frz_pops", pops, 8);

        // reset mid-stream with four rows buffered
        do_reset();
        row_ready = 1'b0;
        send(8, 1'b1, 20, s);
        for (int c = 0; c < 20 && level != 4; c++) tick('0, 1'b1);
        chk("mid_level", level, 4);
        #2 reset = 1'b1;
        #1;
        chk("mid_valid", row_valid, 1'b0);
        chk("mid_level0", level, 0);
        chk("mid_accept", accept, 1'b1);
        chk("mid_data", row_data, '0);
        chk("mid_last", row_last, 1'b0);
        chk("mid_err", err_skew, 1'b0);
        do_reset();
        row_ready = 1'b1;
        send(8, 1'b1, 40, s);
        flush(60);
        chk("mid_pops", pops, 8);
        chk("mid_lasts", last_at.size(), 1);

        // randomized traffic, freezes, clears and backpressure
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            logic en;
            en = $urandom_range(0, 7) != 0;
            row_ready = $urandom_range(0, 3) != 0;
            e = '0;
            if (en && $urandom_range(0, 15) == 0) begin
                e.c = 1'b1;
                e.v = accept & $urandom_range(0, 1);
            end else if (en && accept && $urandom_range(0, 3) != 0) begin
                e.v = 1'b1;
                for (int i = 0; i < N; i++) e.d[i] = $urandom;
            end
            tick(e, en);
        end
        flush(200);
        chk("rnd_err", err_skew, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
